// File: rtl/io_bus_pkg.sv
// Shared definitions for the PDU I/O bus: master state encoding and the
// register map used by the master, the responder and the testbench.
package io_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_POLL  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [7:0] IO_LED     = 8'h00;
  localparam logic [7:0] IO_BTN     = 8'h04;
  localparam logic [7:0] IO_SEG_RDY = 8'h08;
  localparam logic [7:0] IO_SEG     = 8'h0C;
  localparam logic [7:0] IO_SW_AVL  = 8'h10;
  localparam logic [7:0] IO_SW      = 8'h14;
  localparam logic [7:0] IO_CNT     = 8'h18;

endpackage

// File: rtl/io_bus_master.sv
// CPU-side initiator for the 8-bit-address PDU I/O bus. Takes one
// load/store/poll request at a time, checks the I/O window, drives the bus
// from registers only and returns exactly one response per accepted request.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter logic [31:0] IO_BASE      = 32'hFFFF_FF00,
  parameter logic [15:0] POLL_TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_poll,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din
);

  state_e      state_q, state_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [7:0]  io_addr_q, io_addr_d;
  logic [31:0] io_dout_q, io_dout_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        io_we_q, io_we_d;
  logic        io_rd_q, io_rd_d;
  logic        addr_ok;

  // Next-state, captured request fields and strobes decoded from the next state
  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    io_addr_d    = io_addr_q;
    io_dout_d    = io_dout_q;
    poll_cnt_d   = poll_cnt_q;
    addr_ok      = (req_addr[31:8] == IO_BASE[31:8]) && (req_addr[1:0] == 2'b00);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!addr_ok) begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            io_addr_d = req_addr[7:0];
            if (req_we) begin
              io_dout_d = req_wdata;
              state_d   = ST_WRITE;
            end else if (req_poll) begin
              poll_cnt_d = 16'd0;
              state_d    = ST_POLL;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_WRITE: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_READ: begin
        resp_rdata_d = io_din;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_POLL: begin
        if (io_din[0]) begin
          resp_rdata_d = io_din;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end else if (poll_cnt_q == (POLL_TIMEOUT - 16'd1)) begin
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b1;
          state_d      = ST_RESP;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    io_we_d      = (state_d == ST_WRITE);
    io_rd_d      = (state_d == ST_READ);
  end

  // All state and outputs are registered; reset drops any strobe in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      io_addr_q    <= 8'd0;
      io_dout_q    <= 32'd0;
      poll_cnt_q   <= 16'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      io_we_q      <= 1'b0;
      io_rd_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      io_addr_q    <= io_addr_d;
      io_dout_q    <= io_dout_d;
      poll_cnt_q   <= poll_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      io_we_q      <= io_we_d;
      io_rd_q      <= io_rd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign io_addr    = io_addr_q;
  assign io_dout    = io_dout_q;
  assign io_we      = io_we_q;
  assign io_rd      = io_rd_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Testbench for io_bus_master: a main instance with the default poll timeout
// and a second instance with a 4-sample timeout share the same requests and
// the same behavioural responder; results are compared to a transaction model.
module tb_io_bus_master;
  import io_bus_pkg::*;

  localparam int BUDGET = 40;
  localparam int TO_MAIN = 65535;
  localparam int TO_T = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we, req_poll;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, io_we, io_rd;
  logic [31:0] resp_rdata, io_dout, io_din;
  logic [7:0]  io_addr;
  logic        req_ready_t, resp_valid_t, resp_err_t, io_we_t, io_rd_t;
  logic [31:0] resp_rdata_t, io_dout_t, io_din_t;
  logic [7:0]  io_addr_t;

  int checks = 0;
  int failures = 0;

  // Responder state, modified only by the bus and by setup flags
  logic [31:0] rsp_regs [64];
  logic        rsp_sw_avl;
  logic        rsp_seg_bit;
  logic        preload, sw_avl_set;
  logic [31:0] seg_hi;

  // Independent model of the register map
  logic [31:0] exp_regs [64];
  logic        exp_sw_avl;

  logic [7:0] addr_tab [7] = '{IO_LED, IO_BTN, IO_SEG_RDY, IO_SEG, IO_SW_AVL, IO_SW, IO_CNT};

  int          obs_lat, obs_lat_t, obs_we_cnt, obs_rd_cnt, obs_we_cyc, obs_rd_cyc;
  int          obs_busy_ready, obs_we_cnt_t, obs_rd_cnt_t;
  logic [31:0] obs_rdata, obs_rdata_t, obs_we_data;
  logic        obs_err, obs_err_t, obs_after_valid, obs_after_ready, obs_ready_pre;
  logic [7:0]  obs_we_addr;

  io_bus_master dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_poll(req_poll), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din)
  );

  io_bus_master #(.IO_BASE(32'hFFFF_FF00), .POLL_TIMEOUT(16'd4)) dut_t (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_t),
    .req_we(req_we), .req_poll(req_poll), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_t), .resp_rdata(resp_rdata_t), .resp_err(resp_err_t),
    .io_addr(io_addr_t), .io_dout(io_dout_t), .io_we(io_we_t), .io_rd(io_rd_t), .io_din(io_din_t)
  );

  always #5 clk = ~clk;

  // Combinational read data for each master from its own bus address
  always_comb begin
    io_din = rsp_regs[io_addr[7:2]];
    if (io_addr == IO_SEG_RDY) io_din = {seg_hi[31:1], rsp_seg_bit};
    if (io_addr == IO_SW_AVL) io_din = {31'd0, rsp_sw_avl};
    io_din_t = rsp_regs[io_addr_t[7:2]];
    if (io_addr_t == IO_SEG_RDY) io_din_t = {seg_hi[31:1], rsp_seg_bit};
    if (io_addr_t == IO_SW_AVL) io_din_t = {31'd0, rsp_sw_avl};
  end

  // Responder write side and destructive read of the switch register
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) rsp_regs[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (io_we) begin
      rsp_regs[io_addr[7:2]] <= io_dout;
    end
    if (preload) rsp_sw_avl <= 1'b0;
    else if (sw_avl_set) rsp_sw_avl <= 1'b1;
    else if (io_rd && io_addr == IO_SW) rsp_sw_avl <= 1'b0;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] model_read(input logic [7:0] a, input logic bit0);
    if (a == IO_SEG_RDY) return {seg_hi[31:1], bit0};
    if (a == IO_SW_AVL) return {31'd0, exp_sw_avl};
    return exp_regs[a[7:2]];
  endfunction

  // Transaction-level prediction: status bit reads 0 for the first z samples
  task automatic predict(input logic we, input logic poll, input logic [31:0] addr,
                         input logic [31:0] wdata, input int z, input int to, input bit upd,
                         output int e_lat, output logic [31:0] e_rdata, output logic e_err,
                         output int e_we, output int e_rd);
    int k;
    e_we = 0; e_rd = 0; e_err = 1'b0; e_rdata = 32'd0;
    if (addr[31:8] != 24'hFFFFFF || addr[1:0] != 2'b00) begin
      e_lat = 1; e_err = 1'b1;
    end else if (we) begin
      e_lat = 2; e_we = 1;
      if (upd) exp_regs[addr[7:2]] = wdata;
    end else if (!poll) begin
      e_lat = 2; e_rd = 1;
      e_rdata = model_read(addr[7:0], (z < 1));
      if (upd && addr[7:0] == IO_SW) exp_sw_avl = 1'b0;
    end else begin
      k = z + 1;
      if (k <= to) begin
        e_lat = k + 1;
        e_rdata = model_read(addr[7:0], 1'b1);
      end else begin
        e_lat = to + 1; e_err = 1'b1;
      end
    end
  endtask

  // Issues one request and records what both masters do until main is idle again
  task automatic run_req(input logic we, input logic poll, input logic [31:0] addr,
                         input logic [31:0] wdata, input int z);
    obs_lat = 0; obs_lat_t = 0; obs_we_cnt = 0; obs_rd_cnt = 0; obs_we_cyc = 0;
    obs_rd_cyc = 0; obs_busy_ready = 0; obs_we_cnt_t = 0; obs_rd_cnt_t = 0;
    obs_rdata = '0; obs_rdata_t = '0; obs_err = 1'b0; obs_err_t = 1'b0;
    obs_after_valid = 1'b1; obs_after_ready = 1'b0; obs_we_data = '0; obs_we_addr = '0;
    rsp_seg_bit = 1'b0;
    @(negedge clk);
    obs_ready_pre = req_ready;
    req_valid = 1'b1; req_we = we; req_poll = poll; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= BUDGET; i++) begin
      rsp_seg_bit = (i > z);
      if (io_we) begin obs_we_cnt++; obs_we_cyc = i; obs_we_addr = io_addr; obs_we_data = io_dout; end
      if (io_rd) begin obs_rd_cnt++; obs_rd_cyc = i; end
      if (io_we_t) obs_we_cnt_t++;
      if (io_rd_t) obs_rd_cnt_t++;
      if (resp_valid && obs_lat == 0) begin obs_lat = i; obs_rdata = resp_rdata; obs_err = resp_err; end
      if (resp_valid_t && obs_lat_t == 0) begin obs_lat_t = i; obs_rdata_t = resp_rdata_t; obs_err_t = resp_err_t; end
      if (req_ready && (obs_lat == 0 || obs_lat == i)) obs_busy_ready++;
      if (obs_lat != 0 && i == obs_lat + 1) begin
        obs_after_valid = resp_valid; obs_after_ready = req_ready;
        break;
      end
      @(posedge clk); #1;
    end
    rsp_seg_bit = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_poll = 1'b0;
    req_addr = '0; req_wdata = '0; preload = 1'b1; sw_avl_set = 1'b0;
    rsp_seg_bit = 1'b0; seg_hi = 32'd0;
    for (int i = 0; i < 64; i++) exp_regs[i] = 32'hC0DE_0000 | 32'(i);
    exp_sw_avl = 1'b0;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_err, io_we, io_rd, io_addr, io_dout, resp_rdata} !== {1'b1, 4'b0, 8'd0, 64'd0}) begin
      failures++;
      $display("[TB] FAIL reset_main: got ready=%b valid=%b err=%b we=%b rd=%b addr=%h dout=%h rdata=%h want 1 0 0 0 0 00 0 0",
               req_ready, resp_valid, resp_err, io_we, io_rd, io_addr, io_dout, resp_rdata);
    end
    checks++;
    if ({req_ready_t, resp_valid_t, io_we_t, io_rd_t} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL reset_t: got %b want 1000", {req_ready_t, resp_valid_t, io_we_t, io_rd_t});
    end
    @(posedge clk); #1 preload = 1'b0;
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic test_write();
    int el; logic [31:0] er; logic ee; int ew, erd;
    predict(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_A5A5, 0, TO_MAIN, 1'b1, el, er, ee, ew, erd);
    run_req(1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_A5A5, 0);
    checks++;
    if (obs_ready_pre !== 1'b1) begin failures++; $display("[TB] FAIL write_ready_idle: got %b want 1", obs_ready_pre); end
    checks++;
    if (obs_we_cnt != ew || obs_we_cyc != 1) begin
      failures++; $display("[TB] FAIL write_strobe: got count=%0d cycle=%0d want 1 at 1", obs_we_cnt, obs_we_cyc);
    end
    checks++;
    if (obs_we_addr !== 8'h00 || obs_we_data !== 32'h0000_A5A5) begin
      failures++; $display("[TB] FAIL write_bus: got addr=%h data=%h want 00 0000a5a5", obs_we_addr, obs_we_data);
    end
    checks++;
    if (obs_lat != el || obs_err !== ee || obs_rdata !== er) begin
      failures++; $display("[TB] FAIL write_resp: got lat=%0d err=%b rdata=%h want %0d %b %h", obs_lat, obs_err, obs_rdata, el, ee, er);
    end
    checks++;
    if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1 || obs_busy_ready != 0) begin
      failures++; $display("[TB] FAIL write_handshake: got after_valid=%b after_ready=%b busy_ready=%0d want 0 1 0",
                           obs_after_valid, obs_after_ready, obs_busy_ready);
    end
  endtask

  task automatic test_read();
    int el; logic [31:0] er; logic ee; int ew, erd;
    logic [7:0] seq [3] = '{IO_SW_AVL, IO_SW, IO_SW_AVL};
    predict(1'b1, 1'b0, 32'hFFFF_FF14, 32'h0000_00F0, 0, TO_MAIN, 1'b1, el, er, ee, ew, erd);
    run_req(1'b1, 1'b0, 32'hFFFF_FF14, 32'h0000_00F0, 0);
    @(negedge clk) sw_avl_set = 1'b1;
    @(negedge clk) sw_avl_set = 1'b0;
    exp_sw_avl = 1'b1;
    for (int s = 0; s < 3; s++) begin
      predict(1'b0, 1'b0, {24'hFFFFFF, seq[s]}, 32'd0, 0, TO_MAIN, 1'b1, el, er, ee, ew, erd);
      run_req(1'b0, 1'b0, {24'hFFFFFF, seq[s]}, 32'd0, 0);
      checks++;
      if (obs_lat != el || obs_rdata !== er || obs_err !== ee) begin
        failures++; $display("[TB] FAIL read_%0d_resp: got lat=%0d rdata=%h err=%b want %0d %h %b", s, obs_lat, obs_rdata, obs_err, el, er, ee);
      end
      checks++;
      if (obs_rd_cnt != 1 || obs_rd_cyc != 1 || obs_we_cnt != 0) begin
        failures++; $display("[TB] FAIL read_%0d_strobe: got rd=%0d at %0d we=%0d want 1 at 1 we 0", s, obs_rd_cnt, obs_rd_cyc, obs_we_cnt);
      end
    end
  endtask

  task automatic test_poll();
    int el, el_t; logic [31:0] er, er_t; logic ee, ee_t; int ew, erd;
    int zs [3] = '{5, 3, 9};
    for (int s = 0; s < 3; s++) begin
      predict(1'b0, 1'b1, 32'hFFFF_FF08, 32'd0, zs[s], TO_T, 1'b0, el_t, er_t, ee_t, ew, erd);
      predict(1'b0, 1'b1, 32'hFFFF_FF08, 32'd0, zs[s], TO_MAIN, 1'b1, el, er, ee, ew, erd);
      run_req(1'b0, 1'b1, 32'hFFFF_FF08, 32'd0, zs[s]);
      checks++;
      if (obs_lat != el || obs_rdata !== er || obs_err !== ee) begin
        failures++; $display("[TB] FAIL poll_z%0d_main: got lat=%0d rdata=%h err=%b want %0d %h %b", zs[s], obs_lat, obs_rdata, obs_err, el, er, ee);
      end
      checks++;
      if (obs_lat_t != el_t || obs_rdata_t !== er_t || obs_err_t !== ee_t) begin
        failures++; $display("[TB] FAIL poll_z%0d_to4: got lat=%0d rdata=%h err=%b want %0d %h %b", zs[s], obs_lat_t, obs_rdata_t, obs_err_t, el_t, er_t, ee_t);
      end
      checks++;
      if (obs_rd_cnt != 0 || obs_rd_cnt_t != 0 || obs_we_cnt != 0) begin
        failures++; $display("[TB] FAIL poll_z%0d_strobe: got rd=%0d rd_t=%0d we=%0d want 0 0 0", zs[s], obs_rd_cnt, obs_rd_cnt_t, obs_we_cnt);
      end
    end
  endtask

  task automatic test_fault();
    int el; logic [31:0] er; logic ee; int ew, erd;
    logic [31:0] fa [3] = '{32'h0000_0014, 32'hFFFF_FF15, 32'hFFFF_FF02};
    for (int s = 0; s < 3; s++) begin
      predict(s == 2, 1'b0, fa[s], 32'h1234_5678, 0, TO_MAIN, 1'b1, el, er, ee, ew, erd);
      run_req(s == 2, 1'b0, fa[s], 32'h1234_5678, 0);
      checks++;
      if (obs_lat != el || obs_err !== ee || obs_rdata !== er) begin
        failures++; $display("[TB] FAIL fault_%h: got lat=%0d err=%b rdata=%h want %0d %b %h", fa[s], obs_lat, obs_err, obs_rdata, el, ee, er);
      end
      checks++;
      if (obs_we_cnt != 0 || obs_rd_cnt != 0) begin
        failures++; $display("[TB] FAIL fault_%h_strobe: got we=%0d rd=%0d want 0 0", fa[s], obs_we_cnt, obs_rd_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] we_mask, vld_mask, rdy_mask;
    logic [31:0] d;
    d = $urandom;
    we_mask = '0; vld_mask = '0; rdy_mask = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_poll = 1'b0; req_addr = 32'hFFFF_FF04; req_wdata = d;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (i == 9) req_valid = 1'b0;
      we_mask[i] = io_we; vld_mask[i] = resp_valid; rdy_mask[i] = req_ready;
    end
    exp_regs[1] = d;
    checks++;
    if (we_mask !== 10'b0010010010) begin failures++; $display("[TB] FAIL b2b_we: got %b want 0010010010", we_mask); end
    checks++;
    if (vld_mask !== 10'b0100100100) begin failures++; $display("[TB] FAIL b2b_resp: got %b want 0100100100", vld_mask); end
    checks++;
    if (rdy_mask !== 10'b1001001000) begin failures++; $display("[TB] FAIL b2b_ready: got %b want 1001001000", rdy_mask); end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || io_we !== 1'b0 || rsp_regs[1] !== d) begin
      failures++; $display("[TB] FAIL b2b_tail: got valid=%b we=%b reg=%h want 0 0 %h", resp_valid, io_we, rsp_regs[1], d);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int el; logic [31:0] er; logic ee; int ew, erd;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = (s == 1); req_poll = (s == 0);
      req_addr = (s == 0) ? 32'hFFFF_FF08 : 32'hFFFF_FF00; req_wdata = 32'hDEAD_BEEF;
      rsp_seg_bit = 1'b0;
      @(posedge clk); #1 req_valid = 1'b0;
      if (s == 0) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
      end else begin
        checks++;
        if (io_we !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_we_before: got %b want 1", io_we); end
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err, io_we, io_rd, io_addr, io_dout, resp_rdata} !== {1'b1, 4'b0, 8'd0, 64'd0}) begin
        failures++;
        $display("[TB] FAIL rstmid_%0d_values: got ready=%b valid=%b err=%b we=%b rd=%b addr=%h dout=%h rdata=%h want reset values",
                 s, req_ready, resp_valid, resp_err, io_we, io_rd, io_addr, io_dout, resp_rdata);
      end
      @(negedge clk) rstn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (resp_valid || io_we || io_rd || resp_valid_t || io_we_t || !req_ready) pulses++;
      end
      checks++;
      if (pulses != 0) begin failures++; $display("[TB] FAIL rstmid_%0d_quiet: got %0d active cycles want 0", s, pulses); end
    end
    predict(1'b0, 1'b0, 32'hFFFF_FF00, 32'd0, 0, TO_MAIN, 1'b1, el, er, ee, ew, erd);
    run_req(1'b0, 1'b0, 32'hFFFF_FF00, 32'd0, 0);
    checks++;
    if (obs_rdata !== er) begin failures++; $display("[TB] FAIL rstmid_write_dropped: got %h want %h", obs_rdata, er); end
  endtask

  task automatic test_random();
    int el, el_t; logic [31:0] er, er_t; logic ee, ee_t; int ew, erd, ew_t, erd_t;
    logic [31:0] a, d; logic we, poll; int z, kind;
    seg_hi = $urandom;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      d = $urandom; z = $urandom_range(0, 6);
      we = (kind >= 2 && kind <= 4); poll = (kind >= 8);
      a = {24'hFFFFFF, addr_tab[$urandom_range(0, 6)]};
      if (poll) a = 32'hFFFF_FF08;
      if (kind <= 1) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          a[31:8] = 24'hFFFFFF; a[1:0] = 2'($urandom_range(1, 3));
        end else if (a[31:8] == 24'hFFFFFF) begin
          a[31] = 1'b0;
        end
      end
      predict(we, poll, a, d, z, TO_T, 1'b0, el_t, er_t, ee_t, ew_t, erd_t);
      predict(we, poll, a, d, z, TO_MAIN, 1'b1, el, er, ee, ew, erd);
      run_req(we, poll, a, d, z);
      checks++;
      if (obs_lat != el || obs_rdata !== er || obs_err !== ee) begin
        failures++; $display("[TB] FAIL rand%0d_main a=%h we=%b poll=%b z=%0d: got lat=%0d rdata=%h err=%b want %0d %h %b",
                             n, a, we, poll, z, obs_lat, obs_rdata, obs_err, el, er, ee);
      end
      checks++;
      if (obs_lat_t != el_t || obs_rdata_t !== er_t || obs_err_t !== ee_t) begin
        failures++; $display("[TB] FAIL rand%0d_to4 a=%h z=%0d: got lat=%0d rdata=%h err=%b want %0d %h %b",
                             n, a, z, obs_lat_t, obs_rdata_t, obs_err_t, el_t, er_t, ee_t);
      end
      checks++;
      if (obs_we_cnt != ew || obs_rd_cnt != erd || obs_we_cnt_t != ew_t || obs_rd_cnt_t != erd_t) begin
        failures++; $display("[TB] FAIL rand%0d_strobes: got we=%0d rd=%0d we_t=%0d rd_t=%0d want %0d %0d %0d %0d",
                             n, obs_we_cnt, obs_rd_cnt, obs_we_cnt_t, obs_rd_cnt_t, ew, erd, ew_t, erd_t);
      end
      checks++;
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1 || obs_busy_ready != 0) begin
        failures++; $display("[TB] FAIL rand%0d_handshake: got after_valid=%b after_ready=%b busy_ready=%0d want 0 1 0",
                             n, obs_after_valid, obs_after_ready, obs_busy_ready);
      end
    end
  endtask

  // Directed scenarios first, then randomized traffic against the model
  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
